// File: rtl/sample_iterator_pkg.sv
// Shared rasterizer definitions used by the sample iterator.
//   WAIT_STATE / TEST_STATE : FSM state encodings (idle / walking a box)
//   LL / UR                 : bounding-box corner indices
//   step_from_onehot        : sample step (fixed point) from the one-hot select
package rast_pkg;

   localparam logic [0:0] WAIT_STATE = 1'b0;
   localparam logic [0:0] TEST_STATE = 1'b1;

   localparam int unsigned LL = 0;
   localparam int unsigned UR = 1;

   // Unrecognised selects fall back to one sample per pixel.
   function automatic logic [31:0] step_from_onehot(input logic [3:0] sel,
                                                    input int unsigned radix);
      logic [31:0] step;
      case (sel)
         4'b0100: step = 32'd1 << (radix - 1);
         4'b0010: step = 32'd1 << (radix - 2);
         4'b0001: step = 32'd1 << (radix - 3);
         default: step = 32'd1 << radix;
      endcase
      return step;
   endfunction

endpackage

// File: rtl/sample_iterator_if.sv
// Bundle between the bounding-box stage, the sample iterator and the sample test.
//   Upstream  : tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU
//               with halt_RnnnnL returned (low = hold).
//   Downstream: tri_R14S, color_R14U, sample_R14S, validSamp_R14H.
//   slave  modport : the sample iterator
//   master modport : the environment (upstream source + downstream sink)
interface sample_iterator_if #(
   parameter int SIGFIG = 24,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
);
   logic signed [SIGFIG-1:0] tri_R13S   [VERTS-1:0][AXIS-1:0];
   logic        [SIGFIG-1:0] color_R13U [COLORS-1:0];
   logic signed [SIGFIG-1:0] box_R13S   [1:0][1:0];
   logic                     validTri_R13H;
   logic        [3:0]        subSample_RnnnnU;
   logic                     halt_RnnnnL;

   logic signed [SIGFIG-1:0] tri_R14S    [VERTS-1:0][AXIS-1:0];
   logic        [SIGFIG-1:0] color_R14U  [COLORS-1:0];
   logic signed [SIGFIG-1:0] sample_R14S [1:0];
   logic                     validSamp_R14H;

   modport slave (
      input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      output halt_RnnnnL,
      output tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );

   modport master (
      output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      input  halt_RnnnnL,
      input  tri_R14S, color_R14U, sample_R14S, validSamp_R14H
   );
endinterface

// File: rtl/sample_iterator.sv
// Sample iterator: accepts one triangle plus its bounding box and walks every
// sample location inside the box in raster order, one location per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sample_iterator_if (upstream triangle/box in,
//              halt_RnnnnL back, latched triangle/colour and sample out)
module sample_iterator
   import rast_pkg::*;
#(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic             clk,
   input  logic             rst,
   sample_iterator_if.slave bus
);

   logic [0:0]               state;
   logic                     valid_q;
   logic signed [SIGFIG-1:0] tri_q   [VERTS-1:0][AXIS-1:0];
   logic        [SIGFIG-1:0] color_q [COLORS-1:0];
   logic signed [SIGFIG-1:0] ll_x, ur_x, ur_y;
   logic        [SIGFIG-1:0] step_q;
   logic                     single_q;
   logic signed [SIGFIG-1:0] x_q, y_q;

   // One extra bit so stepping past the top of the coordinate range
   // cannot wrap negative and keep the walk alive.
   logic signed [SIGFIG:0]   x_nxt, y_nxt;
   logic                     x_fits, y_fits;

   always_comb begin
      x_nxt  = $signed((SIGFIG+1)'(x_q)) + $signed({1'b0, step_q});
      y_nxt  = $signed((SIGFIG+1)'(y_q)) + $signed({1'b0, step_q});
      // An inverted box yields only its lower-left sample, so both advance
      // paths are suppressed rather than letting one axis keep walking.
      x_fits = !single_q && (x_nxt <= $signed((SIGFIG+1)'(ur_x)));
      y_fits = !single_q && (y_nxt <= $signed((SIGFIG+1)'(ur_y)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WAIT_STATE;
         valid_q  <= 1'b0;
         tri_q    <= '{default: '0};
         color_q  <= '{default: '0};
         ll_x     <= '0;
         ur_x     <= '0;
         ur_y     <= '0;
         step_q   <= '0;
         single_q <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         case (state)
            WAIT_STATE: begin
               if (bus.validTri_R13H) begin
                  tri_q    <= bus.tri_R13S;
                  color_q  <= bus.color_R13U;
                  ll_x     <= bus.box_R13S[LL][0];
                  ur_x     <= bus.box_R13S[UR][0];
                  ur_y     <= bus.box_R13S[UR][1];
                  step_q   <= SIGFIG'(step_from_onehot(bus.subSample_RnnnnU, RADIX));
                  single_q <= (bus.box_R13S[UR][0] < bus.box_R13S[LL][0]) ||
                              (bus.box_R13S[UR][1] < bus.box_R13S[LL][1]);
                  x_q      <= bus.box_R13S[LL][0];
                  y_q      <= bus.box_R13S[LL][1];
                  valid_q  <= 1'b1;
                  state    <= TEST_STATE;
               end
            end
            TEST_STATE: begin
               if (x_fits) begin
                  x_q <= x_nxt[SIGFIG-1:0];
               end else if (y_fits) begin
                  x_q <= ll_x;
                  y_q <= y_nxt[SIGFIG-1:0];
               end else begin
                  valid_q <= 1'b0;
                  state   <= WAIT_STATE;
               end
            end
            default: state <= WAIT_STATE;
         endcase
      end
   end

   assign bus.halt_RnnnnL    = (state == WAIT_STATE);
   assign bus.tri_R14S       = tri_q;
   assign bus.color_R14U     = color_q;
   assign bus.sample_R14S[0] = x_q;
   assign bus.sample_R14S[1] = y_q;
   assign bus.validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Scoreboard bench for sample_iterator: the driver pushes every expected
// sample (with its expected cycle) when a triangle is accepted; the monitor
// checks valid/halt every cycle and pops/compares whenever a sample is due.
`timescale 1ns/1ps
module tb_sample_iterator;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;
   localparam int TRIW   = SIGFIG * VERTS * AXIS;
   localparam int COLW   = SIGFIG * COLORS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sample_iterator_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

   sample_iterator #(
      .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int              x;
      int              y;
      int              cyc;
      logic [TRIW-1:0] tf;
      logic [COLW-1:0] cf;
   } exp_t;

   exp_t q[$];
   int   cyc        = 0;
   int   busy_until = -1;
   int   compared   = 0;
   int   mismatched = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_int(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_vec(input string name, input logic [TRIW-1:0] act, input logic [TRIW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ref_step(input logic [3:0] ss);
      case (ss)
         4'b1000: return 1024;
         4'b0100: return 512;
         4'b0010: return 256;
         4'b0001: return 128;
         default: return 1024;
      endcase
   endfunction

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t            e;
      logic            exp_v;
      logic [TRIW-1:0] tf;
      logic [COLW-1:0] cf;
      forever begin
         @(posedge clk);
         #1;
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tf[(v*AXIS+a)*SIGFIG +: SIGFIG] = bus.tri_R14S[v][a];
         for (int c = 0; c < COLORS; c++)
            cf[c*SIGFIG +: SIGFIG] = bus.color_R14U[c];
         if (rst) begin
            q.delete();
            busy_until = cyc - 1;
            chk_int("rst_valid", int'(bus.validSamp_R14H), 0);
            chk_int("rst_halt", int'(bus.halt_RnnnnL), 1);
            chk_int("rst_x", int'(bus.sample_R14S[0]), 0);
            chk_int("rst_y", int'(bus.sample_R14S[1]), 0);
            chk_vec("rst_tri", tf, '0);
            chk_vec("rst_color", TRIW'(cf), '0);
         end else begin
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            chk_int("valid", int'(bus.validSamp_R14H), int'(exp_v));
            chk_int("halt", int'(bus.halt_RnnnnL), int'(cyc > busy_until));
            if (exp_v) begin
               e = q.pop_front();
               if (bus.validSamp_R14H) begin
                  chk_int("sample_x", int'(bus.sample_R14S[0]), e.x);
                  chk_int("sample_y", int'(bus.sample_R14S[1]), e.y);
                  chk_vec("tri", tf, e.tf);
                  chk_vec("color", TRIW'(cf), TRIW'(e.cf));
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input int llx, input int lly, input int urx, input int ury,
                       input logic [3:0] ss);
      logic [TRIW-1:0] tf;
      logic [COLW-1:0] cf;
      exp_t            e;
      int              step, start, n;
      bit              done;
      done = 1'b0;
      @(negedge clk);
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++) begin
            bus.tri_R13S[v][a] = SIGFIG'($urandom);
            tf[(v*AXIS+a)*SIGFIG +: SIGFIG] = bus.tri_R13S[v][a];
         end
      for (int c = 0; c < COLORS; c++) begin
         bus.color_R13U[c] = SIGFIG'($urandom);
         cf[c*SIGFIG +: SIGFIG] = bus.color_R13U[c];
      end
      bus.box_R13S[0][0]   = SIGFIG'(llx);
      bus.box_R13S[0][1]   = SIGFIG'(lly);
      bus.box_R13S[1][0]   = SIGFIG'(urx);
      bus.box_R13S[1][1]   = SIGFIG'(ury);
      bus.subSample_RnnnnU = ss;
      bus.validTri_R13H    = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         if (t > 0) @(negedge clk);
         if (bus.halt_RnnnnL) begin
            // Accepted on the coming edge; samples fill the following cycles.
            step  = ref_step(ss);
            start = cyc + 1;
            n     = 0;
            e.tf  = tf;
            e.cf  = cf;
            if (urx < llx || ury < lly) begin
               e.x = llx; e.y = lly; e.cyc = start;
               q.push_back(e);
               n = 1;
            end else begin
               for (int y = lly; y <= ury; y += step)
                  for (int x = llx; x <= urx; x += step) begin
                     e.x = x; e.y = y; e.cyc = start + n;
                     q.push_back(e);
                     n++;
                  end
            end
            busy_until = start + n - 1;
            done = 1'b1;
         end
      end
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: halt stayed %0b, required 1 within 200 cycles", bus.halt_RnnnnL);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic [3:0] ss);
      @(negedge clk);
      bus.validTri_R13H    = 1'b0;
      bus.subSample_RnnnnU = ss;
      bus.box_R13S[0][0]   = SIGFIG'($urandom);
      bus.box_R13S[1][1]   = SIGFIG'($urandom);
      for (int i = 1; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.validTri_R13H = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin : stim
      int   s, llx, lly, w, h;
      logic [3:0] ss;
      bus.validTri_R13H    = 1'b0;
      bus.subSample_RnnnnU = 4'b1000;
      bus.box_R13S         = '{default: '0};
      bus.tri_R13S         = '{default: '0};
      bus.color_R13U       = '{default: '0};
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      send(0, 0, 2048, 1024, 4'b1000);          idle(10, 4'b1000);
      send(-3072, 5120, -3072, 5120, 4'b1000);  idle(3, 4'b1000);
      send(0, 0, 1024, 0, 4'b0100);             idle(6, 4'b0001);
      send(0, 0, 1024, 1024, 4'b1000);
      send(-2048, -1024, 0, 0, 4'b1000);        idle(10, 4'b0010);
      send(0, 0, 4096, 4096, 4'b1000);          idle(5, 4'b1000);
      do_reset();                               idle(3, 4'b1000);
      send(8387584, 8387584, 8387584, 8387584, 4'b1000); idle(3, 4'b1000);
      send(8386560, 0, 8387584, 1024, 4'b1000); idle(6, 4'b1000);
      send(1024, 0, 0, 2048, 4'b1000);          idle(3, 4'b1000);
      send(0, 2048, 1024, 0, 4'b0001);          idle(3, 4'b1000);
      send(0, 0, 0, 0, 4'b0110);                idle(3, 4'b1000);

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: ss = 4'b1000;
            1: ss = 4'b0100;
            2: ss = 4'b0010;
            3: ss = 4'b0001;
            default: ss = 4'($urandom);
         endcase
         s   = ref_step(ss);
         llx = (int'($urandom_range(0, 16)) - 8) * s;
         lly = (int'($urandom_range(0, 16)) - 8) * s;
         w   = int'($urandom_range(0, 4));
         h   = int'($urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0)
            send(llx, lly, llx - s, lly + h * s, ss);
         else
            send(llx, lly, llx + w * s, lly + h * s, ss);
         if ($urandom_range(0, 14) == 0) do_reset();
         else if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 4)), 4'($urandom));
      end

      idle(1, 4'b1000);
      for (int t = 0; t < 500 && q.size() > 0; t++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk_int("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
